// File: rtl/puneh_mem_bridge_pkg.sv
// rtl/puneh_mem_bridge_pkg.sv - shared state encodings and defaults for the PUNEH memory bridge
package puneh_mem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int          ADDR_W_DEF   = 12;
   localparam int          DATA_W_DEF   = 16;
   localparam int          TIMEOUT_DEF  = 15;
   localparam int          CNT_W_DEF    = 4;
   localparam logic [15:0] ERR_DATA_DEF = 16'hFFFF;

endpackage

// File: rtl/puneh_mem_bridge_wdt_counter.sv
// rtl/puneh_mem_bridge_wdt_counter.sv - watchdog counter bounding how long an access may wait for m_ack
module puneh_wdt_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] max,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   // Saturates at max so a stray enable can never wrap back below the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == max);

endmodule

// File: rtl/puneh_mem_bridge.sv
// rtl/puneh_mem_bridge.sv - turns PUNEH readMEM/writeMEM strobes into a req/ack bus access with stall
module puneh_mem_bridge
   import puneh_mem_bridge_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                TIMEOUT  = TIMEOUT_DEF,
   parameter int                CNT_W    = CNT_W_DEF,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              readMEM,
   input  logic              writeMEM,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              bus_err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);

   state_t state, state_next;
   logic   start, fin_ack, fin_to, wdt_en, expired;
   logic   to, ovl;

   puneh_wdt_counter #(.CNT_W(CNT_W)) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .en      (wdt_en),
      .max     (CNT_W'(TIMEOUT - 1)),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An ack that lands on the expiry cycle completes normally rather than aborting.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      start      = 1'b0;
      fin_ack    = 1'b0;
      fin_to     = 1'b0;
      wdt_en     = 1'b0;
      bus_err    = 1'b0;
      case (state)
         IDLE: begin
            if (readMEM || writeMEM) begin
               stall      = 1'b1;
               start      = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            stall  = 1'b1;
            wdt_en = 1'b1;
            if (m_ack) begin
               fin_ack    = 1'b1;
               state_next = DONE;
            end else if (expired) begin
               fin_to     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            bus_err    = to || ovl;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Overlapping strobes resolve to a write; the overlap is only reported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         rdata   <= '0;
         to      <= 1'b0;
         ovl     <= 1'b0;
      end else begin
         if (start) begin
            m_req   <= 1'b1;
            m_we    <= writeMEM;
            m_addr  <= addr;
            m_wdata <= wdata;
            ovl     <= readMEM && writeMEM;
         end
         if (fin_ack) begin
            m_req <= 1'b0;
            if (!m_we) begin
               rdata <= m_rdata;
            end
         end
         if (fin_to) begin
            m_req <= 1'b0;
            to    <= 1'b1;
            if (!m_we) begin
               rdata <= ERR_DATA;
            end
         end
         if (state == DONE) begin
            to  <= 1'b0;
            ovl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_puneh_mem_bridge.sv
// tb/tb_puneh_mem_bridge.sv - self-checking bench for puneh_mem_bridge against a transaction-level model
`timescale 1ns/1ps
module tb_puneh_mem_bridge;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        readMEM, writeMEM;
   logic [11:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        stall, bus_err;
   logic        m_req, m_we;
   logic [11:0] m_addr;
   logic [15:0] m_wdata;
   logic        m_ack;
   logic [15:0] m_rdata;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [int];
   logic [15:0] rdata_model;

   puneh_mem_bridge dut (
      .clk      (clk),
      .rst      (rst),
      .readMEM  (readMEM),
      .writeMEM (writeMEM),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .stall    (stall),
      .bus_err  (bus_err),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ack    (m_ack),
      .m_rdata  (m_rdata)
   );

   always #5 clk = ~clk;

   // One whole access; delay = WAIT cycles before ack, delay >= TIMEOUT means memory never answers.
   task automatic run_access(input logic rd, input logic wr, input logic [11:0] a,
                             input logic [15:0] wd, input int delay, input string name);
      int          stall_n, req_n;
      bit          done, stable, stray_err, acked;
      logic [15:0] rd_val;
      int          exp_stall, exp_req;
      logic        exp_err;
      acked     = (delay < TIMEOUT);
      exp_stall = (acked ? delay : TIMEOUT - 1) + 2;
      exp_req   = acked ? delay + 1 : TIMEOUT;
      exp_err   = !acked || (rd && wr);
      if (!mem.exists(int'(a))) mem[int'(a)] = 16'($urandom);
      rd_val = mem[int'(a)];
      @(negedge clk);
      readMEM = rd; writeMEM = wr; addr = a; wdata = wd; m_ack = 1'b0;
      stall_n = 0; req_n = 0; done = 0; stable = 1; stray_err = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         if (m_req) begin
            if (m_we !== wr || m_addr !== a || m_wdata !== wd) stable = 0;
            if (req_n == delay) begin
               m_ack = 1'b1;
               m_rdata = wr ? 16'($urandom) : rd_val;
            end else begin
               m_ack = 1'b0;
               m_rdata = 16'($urandom);
            end
            req_n++;
         end else begin
            m_ack = 1'b0;
         end
         if (stall) stall_n++;
         else if (c > 0) done = 1;
         if (!done && bus_err) stray_err = 1;
         if (!done) @(negedge clk);
      end
      if (wr && acked) mem[int'(a)] = wd;
      if (!wr) rdata_model = acked ? rd_val : 16'hFFFF;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s completion: no DONE within budget, stall cycles %0d", name, stall_n);
      end
      checks++;
      if (stall_n != exp_stall) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_n, exp_stall);
      end
      checks++;
      if (req_n != exp_req) begin
         errors++;
         $display("FAIL %s req_cycles: got %0d expected %0d", name, req_n, exp_req);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL %s req_stability: m_we/m_addr/m_wdata changed or wrong, expected we=%0b addr=%h wdata=%h", name, wr, a, wd);
      end
      checks++;
      if (rdata !== rdata_model) begin
         errors++;
         $display("FAIL %s rdata: got %h expected %h", name, rdata, rdata_model);
      end
      checks++;
      if (bus_err !== exp_err || stray_err) begin
         errors++;
         $display("FAIL %s bus_err: got %b (early pulse %0b) expected %b", name, bus_err, stray_err, exp_err);
      end
      readMEM = 1'b0; writeMEM = 1'b0; m_ack = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || m_req !== 1'b0 || bus_err !== 1'b0) begin
         errors++;
         $display("FAIL %s back_to_idle: stall=%b m_req=%b bus_err=%b expected 0 0 0", name, stall, m_req, bus_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; readMEM = 1'b0; writeMEM = 1'b0; addr = '0; wdata = '0;
      m_ack = 1'b0; m_rdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      rdata_model = 16'h0000;
      checks++;
      if ({m_req, m_we, m_addr, m_wdata, rdata, bus_err, stall} !== '0) begin
         errors++;
         $display("FAIL reset_values: req=%b we=%b addr=%h wdata=%h rdata=%h err=%b stall=%b expected all 0",
                  m_req, m_we, m_addr, m_wdata, rdata, bus_err, stall);
      end
   endtask

   task automatic test_directed();
      mem[12'h010] = 16'h1234;
      run_access(1'b1, 1'b0, 12'h010, 16'h0000, 0, "zero_wait_read");
      run_access(1'b0, 1'b1, 12'h0FF, 16'hA5A5, 3, "write_3_waits");
      run_access(1'b1, 1'b0, 12'h020, 16'h0000, TIMEOUT + 5, "timeout_read");
      mem[12'h030] = 16'h0042;
      run_access(1'b1, 1'b0, 12'h030, 16'h0000, TIMEOUT - 1, "ack_on_expiry");
      run_access(1'b1, 1'b1, 12'h040, 16'hBEEF, 1, "overlap");
      run_access(1'b1, 1'b0, 12'h040, 16'h0000, 2, "readback_overlap_write");
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      m_ack = 1'b1; m_rdata = 16'h5555;
      @(negedge clk);
      m_ack = 1'b0;
      #1;
      checks++;
      if (m_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0 || rdata !== rdata_model) begin
         errors++;
         $display("FAIL stray_ack: req=%b stall=%b err=%b rdata=%h expected 0 0 0 %h",
                  m_req, stall, bus_err, rdata, rdata_model);
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      readMEM = 1'b1; addr = 12'h123; wdata = 16'h7777; m_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      rdata_model = 16'h0000;
      checks++;
      if ({m_req, m_we, m_addr, m_wdata, rdata, bus_err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_wait: req=%b we=%b addr=%h wdata=%h rdata=%h err=%b expected all 0",
                  m_req, m_we, m_addr, m_wdata, rdata, bus_err);
      end
      readMEM = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || m_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: stall=%b m_req=%b expected 0 0", stall, m_req);
      end
      run_access(1'b1, 1'b0, 12'h123, 16'h0000, 1, "clean_after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic        rd, wr;
         int          sel, dly;
         sel = int'($urandom_range(0, 9));
         rd  = (sel < 5) || (sel == 9);
         wr  = (sel >= 5);
         dly = int'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0) dly = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
         run_access(rd, wr, 12'($urandom_range(0, 7)), 16'($urandom), dly, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stray_ack();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
